// File: rtl/alu_pkt_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkt_pkg
// Shared types and constants for the ALU command packet receiver.
//   opcode_e     : recognised arithmetic opcodes
//   state_e      : header/payload parser states
//   HDR_BYTES    : opcode, reserved, LEN lo, LEN hi
//   pkt_is_legal : opcode/length legality check applied once LEN is complete
// -----------------------------------------------------------------------------
package alu_pkt_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'hA0,
        OP_MUL = 8'hA1,
        OP_DIV = 8'hA2
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RSVD   = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_DRAIN  = 3'd5
    } state_e;

    localparam int HDR_BYTES     = 4;
    localparam int MIN_ARITH_LEN = 12;
    localparam int DIV_LEN       = 12;

    // LEN counts the whole packet; (LEN-4) % 4 == 0 is the same as LEN % 4 == 0.
    function automatic logic pkt_is_legal(input logic [7:0] op, input logic [15:0] len);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_MUL: ok = (len >= 16'(MIN_ARITH_LEN)) && (len[1:0] == 2'b00);
            OP_DIV:         ok = (len == 16'(DIV_LEN));
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_word_packer.sv
// -----------------------------------------------------------------------------
// alu_word_packer
// Assembles little-endian bytes into operand words and holds one completed
// word in an AXI-Stream style output register.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   clear_i              : discard the partially assembled word
//   byte_vld_i, byte_i   : accepted payload byte
//   last_i               : the byte being accepted ends the packet
//   force_last_i         : mark a pending output word as the final one
//   byte_idx_o           : position of the next byte within the word
//   m_axis_tdata/tvalid/tlast, m_axis_tready : output word handshake
// -----------------------------------------------------------------------------
module alu_word_packer #(
    parameter int DATA_WIDTH_P = 8,
    parameter int WORD_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    byte_vld_i,
    input  logic [DATA_WIDTH_P-1:0] byte_i,
    input  logic                    last_i,
    input  logic                    force_last_i,
    output logic [1:0]              byte_idx_o,
    output logic [WORD_WIDTH_P-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int ACC_W = WORD_WIDTH_P - DATA_WIDTH_P;

    // Only the lower three bytes are stored; the fourth goes straight to the output.
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [1:0]              idx_q, idx_d;
    logic [WORD_WIDTH_P-1:0] tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    word_done;

    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        word_done = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            idx_d = '0;
        end else if (byte_vld_i) begin
            for (int i = 0; i < 3; i++) begin
                if (idx_q == 2'(i)) begin
                    acc_d[i*DATA_WIDTH_P +: DATA_WIDTH_P] = byte_i;
                end
            end
            idx_d     = idx_q + 2'd1;
            word_done = (idx_q == 2'd3);
        end

        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        // A new word may land in the same cycle the old one is taken.
        if (word_done) begin
            tdata_d  = {byte_i, acc_q};
            tvalid_d = 1'b1;
            tlast_d  = last_i;
        end
        if (force_last_i && tvalid_d) begin
            tlast_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign byte_idx_o    = idx_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/alu_packet_rx.sv
// -----------------------------------------------------------------------------
// alu_packet_rx
// Parses framed command packets from the UART byte stream into an opcode and
// a stream of 32-bit operand words for the ALU. Malformed packets are drained
// and flagged on err_o so the stream resynchronises on the next header.
// Optional feature macro: ALU_PKT_TIMEOUT_EN (inter-byte timeout).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready   : input byte stream
//   m_axis_tdata/tvalid/tready/tlast : operand word stream to the ALU
//   opcode_o                     : opcode of the packet being delivered
//   busy_o                       : parser is inside a packet
//   err_o                        : one-cycle pulse on a rejected packet
// -----------------------------------------------------------------------------
module alu_packet_rx
    import alu_pkt_pkg::*;
#(
    parameter int DATA_WIDTH_P     = 8,
    parameter int WORD_WIDTH_P     = 32,
    parameter int TIMEOUT_CYCLES_P = 1200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [WORD_WIDTH_P-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [7:0]              opcode_o,
    output logic                    busy_o,
    output logic                    err_o
);

    // Header fields are byte-defined, so the stream must be 8 bits wide.
    if (DATA_WIDTH_P != 8) begin : g_bad_dw
        $error("alu_packet_rx: DATA_WIDTH_P must be 8");
    end
    if (WORD_WIDTH_P != 4 * DATA_WIDTH_P) begin : g_bad_ww
        $error("alu_packet_rx: WORD_WIDTH_P must equal 4*DATA_WIDTH_P");
    end
    if (TIMEOUT_CYCLES_P < 1) begin : g_bad_tmo
        $error("alu_packet_rx: TIMEOUT_CYCLES_P must be positive");
    end

    state_e      state_q;
    logic [7:0]  op_q;
    logic [7:0]  opcode_q;
    logic [7:0]  len_lo_q;
    logic [15:0] bytes_left_q;
    logic        err_q;

    logic        s_fire;
    logic        m_fire;
    logic [1:0]  byte_idx;
    logic [15:0] pkt_len;
    logic        tmo_fire;

    assign s_fire  = s_axis_tvalid && s_axis_tready;
    assign m_fire  = m_axis_tvalid && m_axis_tready;
    assign pkt_len = {s_axis_tdata, len_lo_q};

`ifdef ALU_PKT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES_P + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_fire = (state_q != ST_IDLE) && !s_fire && (tmo_q == TMO_W'(TIMEOUT_CYCLES_P - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_IDLE || s_fire || tmo_fire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Stall the byte that would complete a word while the previous word is
    // still pending, and stop taking bytes once the payload is complete.
    always_comb begin
        s_axis_tready = 1'b1;
        if (state_q == ST_ACCUM) begin
            if ((bytes_left_q == 16'd0) ||
                (byte_idx == 2'd3 && m_axis_tvalid && !m_axis_tready)) begin
                s_axis_tready = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            opcode_q     <= '0;
            len_lo_q     <= '0;
            bytes_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (tmo_fire) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (s_fire) begin
                            op_q    <= s_axis_tdata;
                            state_q <= ST_RSVD;
                        end
                    end
                    ST_RSVD: begin
                        if (s_fire) begin
                            state_q <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (s_fire) begin
                            len_lo_q <= s_axis_tdata;
                            state_q  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (s_fire) begin
                            if (pkt_is_legal(op_q, pkt_len)) begin
                                opcode_q     <= op_q;
                                bytes_left_q <= pkt_len - 16'(HDR_BYTES);
                                state_q      <= ST_ACCUM;
                            end else if (pkt_len > 16'(HDR_BYTES)) begin
                                err_q        <= 1'b1;
                                bytes_left_q <= pkt_len - 16'(HDR_BYTES);
                                state_q      <= ST_DRAIN;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (s_fire) begin
                            bytes_left_q <= bytes_left_q - 16'd1;
                        end
                        if (m_fire && m_axis_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_fire) begin
                            bytes_left_q <= bytes_left_q - 16'd1;
                            if (bytes_left_q == 16'd1) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    alu_word_packer #(
        .DATA_WIDTH_P (DATA_WIDTH_P),
        .WORD_WIDTH_P (WORD_WIDTH_P)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (tmo_fire),
        .byte_vld_i    (s_fire && (state_q == ST_ACCUM)),
        .byte_i        (s_axis_tdata),
        .last_i        (bytes_left_q == 16'd1),
        .force_last_i  (tmo_fire),
        .byte_idx_o    (byte_idx),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    assign opcode_o = opcode_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign err_o    = err_q;

endmodule

// File: tb/tb_alu_packet_rx.sv
module tb_alu_packet_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  opcode_o;
    logic        busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    alu_packet_rx #(
        .DATA_WIDTH_P     (8),
        .WORD_WIDTH_P     (32),
        .TIMEOUT_CYCLES_P (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .opcode_o      (opcode_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int stall_cnt = 0;
    logic [31:0] rx_data_q[$];
    logic        rx_last_q[$];
    logic [7:0]  tx_q[$];

    // Observe handshakes and pulses mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                rx_data_q.push_back(m_axis_tdata);
                rx_last_q.push_back(m_axis_tlast);
            end
            if (err_o) err_cnt++;
            if (s_axis_tvalid && !s_axis_tready) stall_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic q_hdr(input logic [7:0] op, input logic [15:0] len);
        tx_q.push_back(op);
        tx_q.push_back(8'h00);
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
    endtask

    task automatic q_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic send_q();
        logic ok;
        while (tx_q.size() > 0) begin
            s_axis_tdata  = tx_q.pop_front();
            s_axis_tvalid = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL send_byte: s_axis_tready stayed 0 for 200 cycles, required 1");
                tx_q.delete();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_data_q.delete();
        rx_last_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, opcode_o, busy_o, err_o} !== 44'd0) begin
            fails++;
            $display("FAIL reset_outputs: tvalid=%b tdata=%h tlast=%b op=%h busy=%b err=%b, required all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, opcode_o, busy_o, err_o);
        end
        tests++;
        if (s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_tready: got %b required 1", s_axis_tready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        logic [31:0] ed[2];
        logic        el[2];
        int          e0;
        ed = '{32'h00000001, 32'h00000002};
        el = '{1'b0, 1'b1};
        clear_rx();
        e0 = err_cnt;
        q_hdr(8'hA0, 16'h000C);
        q_word(32'h00000001);
        q_word(32'h00000002);
        send_q();
        settle();
        tests++;
        if (rx_data_q.size() !== 2) begin
            fails++;
            $display("FAIL add_count: got %0d words required 2", rx_data_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (i >= rx_data_q.size() || rx_data_q[i] !== ed[i] || rx_last_q[i] !== el[i]) begin
                fails++;
                $display("FAIL add_word%0d: got %h/%b required %h/%b", i,
                         (i < rx_data_q.size()) ? rx_data_q[i] : 32'hx,
                         (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx, ed[i], el[i]);
            end
        end
        tests++;
        if (opcode_o !== 8'hA0) begin
            fails++;
            $display("FAIL add_opcode: got %h required a0", opcode_o);
        end
        tests++;
        if (err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL add_err: got %0d pulses required 0", err_cnt - e0);
        end
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL add_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_mul_backpressure();
        logic [31:0] ed[3];
        logic        el[3];
        int          st0;
        ed = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        el = '{1'b0, 1'b0, 1'b1};
        clear_rx();
        st0 = stall_cnt;
        m_axis_tready = 1'b0;
        q_hdr(8'hA1, 16'h0010);
        for (int b = 1; b <= 12; b++) tx_q.push_back(8'(b));
        fork
            send_q();
            begin
                repeat (20) @(posedge clk);
                #1;
                tests++;
                if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h04030201) begin
                    fails++;
                    $display("FAIL mul_stall: s_tready=%b tvalid=%b tdata=%h required 0/1/04030201",
                             s_axis_tready, m_axis_tvalid, m_axis_tdata);
                end
                m_axis_tready = 1'b1;
            end
        join
        settle();
        tests++;
        if (stall_cnt - st0 <= 0) begin
            fails++;
            $display("FAIL mul_stall_seen: got %0d stalled cycles required >0", stall_cnt - st0);
        end
        tests++;
        if (rx_data_q.size() !== 3) begin
            fails++;
            $display("FAIL mul_count: got %0d words required 3", rx_data_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= rx_data_q.size() || rx_data_q[i] !== ed[i] || rx_last_q[i] !== el[i]) begin
                fails++;
                $display("FAIL mul_word%0d: got %h/%b required %h/%b", i,
                         (i < rx_data_q.size()) ? rx_data_q[i] : 32'hx,
                         (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx, ed[i], el[i]);
            end
        end
        tests++;
        if (opcode_o !== 8'hA1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL mul_end: op=%h busy=%b required a1/0", opcode_o, busy_o);
        end
    endtask

    task automatic test_div_drain();
        logic [31:0] ed[2];
        int          e0;
        ed = '{32'hDEADBEEF, 32'h01234567};
        clear_rx();
        e0 = err_cnt;
        q_hdr(8'hA2, 16'h0010);
        q_hdr(8'hA0, 16'h000C);   // looks like a header but must be drained
        q_word(32'h55AA55AA);
        q_word(32'h000C00A1);
        send_q();
        settle();
        tests++;
        if (err_cnt - e0 !== 1 || rx_data_q.size() !== 0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL div_reject: err=%0d words=%0d busy=%b required 1/0/0",
                     err_cnt - e0, rx_data_q.size(), busy_o);
        end
        q_hdr(8'hA0, 16'h000C);
        q_word(ed[0]);
        q_word(ed[1]);
        send_q();
        settle();
        tests++;
        if (rx_data_q.size() !== 2 || rx_data_q[0] !== ed[0] || rx_data_q[1] !== ed[1] ||
            rx_last_q[0] !== 1'b0 || rx_last_q[1] !== 1'b1) begin
            fails++;
            $display("FAIL div_next_add: words=%0d first=%h second=%h required 2/deadbeef/01234567",
                     rx_data_q.size(), (rx_data_q.size() > 0) ? rx_data_q[0] : 32'hx,
                     (rx_data_q.size() > 1) ? rx_data_q[1] : 32'hx);
        end
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL div_err_once: got %0d pulses required 1", err_cnt - e0);
        end
    endtask

    task automatic test_unknown_opcode();
        int e0;
        clear_rx();
        e0 = err_cnt;
        q_hdr(8'h55, 16'h0004);
        send_q();
        tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL unk_reject: err=%b busy=%b required 1/0", err_o, busy_o);
        end
        q_hdr(8'hA0, 16'h000C);
        q_word(32'h0000CAFE);
        q_word(32'h12345678);
        send_q();
        settle();
        tests++;
        if (rx_data_q.size() !== 2 || rx_data_q[0] !== 32'h0000CAFE || rx_data_q[1] !== 32'h12345678 ||
            rx_last_q[1] !== 1'b1) begin
            fails++;
            $display("FAIL unk_next_add: words=%0d first=%h second=%h required 2/0000cafe/12345678",
                     rx_data_q.size(), (rx_data_q.size() > 0) ? rx_data_q[0] : 32'hx,
                     (rx_data_q.size() > 1) ? rx_data_q[1] : 32'hx);
        end
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL unk_err_once: got %0d pulses required 1", err_cnt - e0);
        end
    endtask

    task automatic test_len_bounds();
        int e0;
        clear_rx();
        e0 = err_cnt;
        q_hdr(8'hA0, 16'h000E);           // not word aligned: 10 bytes drained
        for (int b = 0; b < 10; b++) tx_q.push_back(8'hA0);
        q_hdr(8'hA1, 16'h0008);           // below minimum: 4 bytes drained
        q_word(32'hA1A0A2A0);
        q_hdr(8'hA2, 16'h000C);
        q_word(32'h00000064);
        q_word(32'h00000005);
        send_q();
        settle();
        tests++;
        if (err_cnt - e0 !== 2) begin
            fails++;
            $display("FAIL len_err: got %0d pulses required 2", err_cnt - e0);
        end
        tests++;
        if (rx_data_q.size() !== 2 || rx_data_q[0] !== 32'h00000064 || rx_data_q[1] !== 32'h00000005 ||
            opcode_o !== 8'hA2) begin
            fails++;
            $display("FAIL len_div_ok: words=%0d first=%h op=%h required 2/00000064/a2",
                     rx_data_q.size(), (rx_data_q.size() > 0) ? rx_data_q[0] : 32'hx, opcode_o);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_rx();
        q_hdr(8'hA0, 16'h000C);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        send_q();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, opcode_o, busy_o, err_o} !== 44'd0 ||
            s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: tvalid=%b tdata=%h tlast=%b op=%h busy=%b err=%b s_tready=%b required all 0, s_tready 1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, opcode_o, busy_o, err_o, s_axis_tready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        q_hdr(8'hA0, 16'h000C);
        q_word(32'hA5A5A5A5);
        q_word(32'h00000003);
        send_q();
        settle();
        tests++;
        if (rx_data_q.size() !== 2 || rx_data_q[0] !== 32'hA5A5A5A5 || rx_data_q[1] !== 32'h00000003 ||
            rx_last_q[0] !== 1'b0 || rx_last_q[1] !== 1'b1) begin
            fails++;
            $display("FAIL rst_fresh_add: words=%0d first=%h second=%h required 2/a5a5a5a5/00000003",
                     rx_data_q.size(), (rx_data_q.size() > 0) ? rx_data_q[0] : 32'hx,
                     (rx_data_q.size() > 1) ? rx_data_q[1] : 32'hx);
        end
    endtask

`ifdef ALU_PKT_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int e0;
        clear_rx();
        e0 = err_cnt;
        tx_q.push_back(8'hA0);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h0C);
        send_q();
        n = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (err_o) break;
        end
        tests++;
        if (n !== 100) begin
            fails++;
            $display("FAIL tmo_delay: err after %0d cycles required 100", n);
        end
        settle();
        tests++;
        if (busy_o !== 1'b0 || rx_data_q.size() !== 0 || err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL tmo_state: busy=%b words=%0d err=%0d required 0/0/1",
                     busy_o, rx_data_q.size(), err_cnt - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_mul_backpressure();
        test_div_drain();
        test_unknown_opcode();
        test_len_bounds();
        test_reset_mid_packet();
`ifdef ALU_PKT_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_packet_rx.md
Name: alu_packet_rx

Overview:
- Sits directly downstream of the UART receiver's byte stream (its m_axis_* outputs) and upstream of the ALU datapath.
- Parses framed command packets into an opcode plus a stream of 32-bit little-endian operand words, handshaked to the ALU.
- Rejects malformed packets by draining their remaining bytes and pulsing an error flag, so the byte stream resynchronises to the next header.

Parameters:
- DATA_WIDTH_P, 8, byte width of the input stream.
- WORD_WIDTH_P, 32, operand word width; must equal 4*DATA_WIDTH_P.
- TIMEOUT_CYCLES_P, 1200000, inter-byte timeout in clk cycles (100 ms at 12 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH_P  received byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when high together with tvalid.
- m_axis_tdata  out  WORD_WIDTH_P  operand word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  ALU accepts word.
- m_axis_tlast  out  1  final operand of the packet.
- opcode_o  out  8  opcode of the current packet; stable from header completion until the last-word handshake.
- busy_o  out  1  high whenever state != IDLE.
- err_o  out  1  one-cycle pulse when a packet is rejected.

Behaviour:
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]. LEN is the total packet length in bytes, header included. Operands follow, 4 bytes each, LSB first.
- Legal packets:
  - ADD 0xA0, MUL 0xA1: LEN >= 12 and (LEN-4) % 4 == 0.
  - DIV 0xA2: LEN == 12 exactly.
  - Anything else, including an unknown opcode, is illegal.
- States: IDLE, RSVD, LEN_LO, LEN_HI, ACCUM, DRAIN.
  - IDLE --byte--> RSVD: opcode captured into an internal register.
  - RSVD -> LEN_LO -> LEN_HI: one accepted byte each.
  - On the LEN_HI byte, the legality check runs on the full LEN:
    - Legal: opcode_o updated, bytes_left = LEN-4, go to ACCUM.
    - Illegal with LEN > 4: err_o pulses next cycle, bytes_left = LEN-4, go to DRAIN.
    - Illegal with LEN <= 4: err_o pulses, return to IDLE.
  - ACCUM: each accepted byte is shifted in at byte_idx*8 and decrements bytes_left. On the 4th byte, the word is loaded into the output register the next cycle (1-cycle latency) with tvalid=1 and tlast=(bytes_left==0). The state returns to IDLE on the tlast handshake, not before.
  - DRAIN: accept and discard bytes until bytes_left reaches 0, then go to IDLE.
- s_axis_tready:
  - High in every state except in ACCUM when byte_idx==3 and m_axis_tvalid && !m_axis_tready (a completed word would overwrite the pending one).
  - Low in ACCUM after the final byte until the tlast handshake.
- Simultaneous events: an output handshake and the completion of a new word in the same cycle is legal; the register reloads with tvalid kept high.
- m_axis_tdata/tlast hold while tvalid && !tready.
- Widths: bytes_left is 16-bit, byte_idx is 2-bit and wraps 3 -> 0.
- Reset, at any point including mid-packet: state IDLE; all outputs 0 (tvalid, tdata, tlast, opcode_o, busy_o, err_o); s_axis_tready is 1 out of reset. Partially assembled words are discarded.

Optional Feature:
- Macro: ALU_PKT_TIMEOUT_EN.
- Defined: a counter runs in every non-IDLE state while no byte is accepted and resets on each accepted byte. Reaching TIMEOUT_CYCLES_P pulses err_o, clears the partial word, and forces IDLE. A word already in the output register stays valid until it is accepted, but its tlast is forced to 1.
- Undefined: no counter; the block waits indefinitely for bytes.

Decomposition:
- Package alu_pkt_pkg holds:
  - opcode enum (OP_ADD=8'hA0, OP_MUL=8'hA1, OP_DIV=8'hA2);
  - state enum;
  - HDR_BYTES=4, MIN_ARITH_LEN=12, DIV_LEN=12.
- Natural sub-module: alu_word_packer, a byte-to-word shift register plus the single output register and its valid/ready logic. alu_packet_rx keeps the header FSM, length counter, legality check and drain logic.

Test Plan:
- ADD packet A0 00 0C 00 01 00 00 00 02 00 00 00, m_axis_tready=1 -> words 0x00000001, then 0x00000002 with tlast=1; opcode_o=0xA0; err_o never asserted; busy_o low after the last handshake.
- MUL with LEN=0x0010 (3 operands) and m_axis_tready low for 20 cycles -> s_axis_tready drops when the 2nd word completes; no word is lost or duplicated; tlast only on the 3rd word.
- DIV with LEN=0x0010 -> err_o pulses once; 12 trailing bytes are drained; a following legal ADD packet parses correctly.
- Unknown opcode 0x55 with LEN=0x0004 -> err_o pulses, immediate return to IDLE; the next byte is treated as an opcode.
- rst asserted after the 6th byte of an ADD packet -> all outputs 0 on the next clock; a fresh ADD packet then yields the correct words.
- (ALU_PKT_TIMEOUT_EN, TIMEOUT_CYCLES_P=100) send only A0 00 0C -> err_o pulses 100 cycles after the last byte, busy_o falls, and no output word is produced.
